// File: rtl/output_fetch_cdf_pipe.sv
// -----------------------------------------------------------------------------
// output_fetch_cdf_pipe
//
// Output stage of the histogram-equalisation pipeline. Each accepted pixel is
// turned into a read of the CDF table. The pixel's CDF entry is picked out of
// the wide, multi-entry read word once the memory latency has elapsed. Results
// are delivered in issue order through a small show-ahead FIFO.
//
// Flow control is credit based. A pixel is accepted only if a FIFO slot is
// reserved for it, so reads already in flight always have somewhere to land.
// Bypass pixels skip the memory read but still travel the full latency, which
// keeps them ordered with the mapped pixels around them.
//
// Ports
//   clock               rising-edge clock
//   reset               synchronous, active-high reset
//   DataIn              pixel to map
//   InValid / InReady   input handshake (InReady = a credit is available)
//   Bypass              pass the pixel through unmapped (sampled at issue)
//   output_base_offset  CDF bank select, MSB of ReadAddress (sampled at issue)
//   ReadAddress         {bank, zeros, DataIn[PIXEL_W-1:LANE_W]} (combinational)
//   ReadEnable          read strobe for mapped issues (combinational)
//   ReadBus             read data, valid READ_LATENCY cycles after ReadEnable
//   DataOut / OutValid  FIFO head value and its valid flag
//   OutReady            downstream accepts the head value
//   OutCount            number of results popped since reset (wraps)
// -----------------------------------------------------------------------------
module output_fetch_cdf_pipe #(
    parameter int PIXEL_W      = 8,
    parameter int CDF_W        = 20,
    parameter int BUS_W        = 128,
    parameter int ENTRY_STRIDE = 32,
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PIXEL_W-1:0] DataIn,
    input  logic               InValid,
    output logic               InReady,
    input  logic               Bypass,
    input  logic               output_base_offset,
    output logic [ADDR_W-1:0]  ReadAddress,
    output logic               ReadEnable,
    input  logic [BUS_W-1:0]   ReadBus,
    output logic [CDF_W-1:0]   DataOut,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [31:0]        OutCount
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int LANES  = BUS_W / ENTRY_STRIDE;
    localparam int LANE_W = $clog2(LANES);
    // Zero padding between the bank bit and the word index in ReadAddress.
    localparam int PAD_W  = ADDR_W - 1 - (PIXEL_W - LANE_W);
    // Credits and occupancy must be able to hold the value FIFO_DEPTH itself.
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    // Per-read bookkeeping that rides alongside the memory access.
    typedef struct packed {
        logic               valid;
        logic [LANE_W-1:0]  lane;
        logic               bypass;
        logic [PIXEL_W-1:0] pixel;
    } tag_t;

    // -------------------------------------------------------------------------
    // Issue side
    // -------------------------------------------------------------------------
    logic [CRED_W-1:0] credits;
    logic              issue;
    tag_t              issue_tag;

    // A credit is a FIFO slot reserved for a pixel that has not landed yet.
    // Reset holds InReady low so nothing is accepted during the reset cycle.
    assign InReady     = !reset && (credits != '0);
    assign issue       = InValid && InReady;
    assign ReadEnable  = issue && !Bypass;
    assign ReadAddress = {output_base_offset, {PAD_W{1'b0}}, DataIn[PIXEL_W-1:LANE_W]};

    assign issue_tag = '{
        valid:  issue,
        lane:   DataIn[LANE_W-1:0],
        bypass: Bypass,
        pixel:  DataIn
    };

    // -------------------------------------------------------------------------
    // Tag pipe: delays the tag so that it meets its read data at the tail
    // -------------------------------------------------------------------------
    tag_t tail_tag;

    if (READ_LATENCY == 0) begin : g_no_pipe
        // The read data comes back in the issue cycle, so the tag is used as is.
        assign tail_tag = issue_tag;
    end else begin : g_pipe
        tag_t stage [READ_LATENCY];

        // NOTE: state registers use non-blocking assignments so that every
        // stage samples the value its neighbour held before this clock edge.
        always_ff @(posedge clock) begin
            if (reset) begin
                // Clearing only the valid bits is enough to drop every read
                // in flight; the payload is meaningless without them.
                for (int i = 0; i < READ_LATENCY; i++) begin
                    stage[i].valid <= 1'b0;
                end
            end else begin
                stage[0] <= issue_tag;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign tail_tag = stage[READ_LATENCY-1];
    end

    // -------------------------------------------------------------------------
    // Capture: pick this pixel's entry out of the packed read word
    // -------------------------------------------------------------------------
    logic [CDF_W-1:0] lane_data [LANES];
    logic [CDF_W-1:0] push_data;
    logic             push;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_data[g] = ReadBus[g*ENTRY_STRIDE +: CDF_W];
    end

    // Bits of each slot above CDF_W carry nothing for this stage.
    logic unused_read_bus;
    assign unused_read_bus = ^ReadBus;

    // Bypass items never look at ReadBus, which may hold anything that cycle.
    assign push      = tail_tag.valid;
    assign push_data = tail_tag.bypass ? CDF_W'(tail_tag.pixel)
                                       : lane_data[tail_tag.lane];

    // -------------------------------------------------------------------------
    // Result FIFO (show-ahead)
    // -------------------------------------------------------------------------
    logic [CDF_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CRED_W-1:0] occupancy;
    logic              pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    assign OutValid = (occupancy != '0);
    assign pop      = OutValid && OutReady;

    // An empty FIFO shows zero, so uninitialised storage never reaches DataOut.
    assign DataOut  = OutValid ? fifo_mem[rd_ptr] : '0;

    // NOTE: the storage array has no reset. Only the pointers and the
    // occupancy decide what is visible, so stale contents are harmless and the
    // array can map onto plain RAM cells.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // A push and a pop in the same cycle leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CRED_ONE;
                2'b01:   occupancy <= occupancy - CRED_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Credits and result counter
    // -------------------------------------------------------------------------
    // Issue consumes a slot and pop frees one. A push only turns a reserved
    // slot into an occupied one, so it leaves the credits alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            credits  <= CRED_FULL;
            OutCount <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   credits <= credits - CRED_ONE;
                2'b01:   credits <= credits + CRED_ONE;
                default: credits <= credits;
            endcase
            if (pop) begin
                OutCount <= OutCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_output_fetch_cdf_pipe.sv
// -----------------------------------------------------------------------------
// tb_output_fetch_cdf_pipe
//
// Three copies of output_fetch_cdf_pipe with read latencies of 0, 2 and 3 share
// one clock and one reset. Each copy has a behavioural CDF memory. For a read
// issued at address A, the memory returns a word in which lane l holds
// {12'hA5A, 4'h5, A[15], 3'b000, A[5:0], l, 4'hC}, READ_LATENCY cycles after
// the read. In every other cycle it drives a garbage pattern.
//
// The expected result of a mapped pixel is derived from the pixel and the bank
// alone. The expected result of a bypass pixel is the zero-extended pixel.
// -----------------------------------------------------------------------------
module tb_output_fetch_cdf_pipe;

    localparam int          N       = 3;
    localparam logic [127:0] GARBAGE = {4{32'hDEAD_BEEF}};

    typedef struct {
        logic [7:0]  pix;
        logic        bank;
        logic        byp;
        logic [19:0] exp;
    } item_t;

    logic clock = 1'b0;
    logic reset;

    logic [7:0]   data_in      [N];
    logic         in_valid     [N];
    logic         in_ready     [N];
    logic         bypass       [N];
    logic         base         [N];
    logic [15:0]  read_address [N];
    logic         read_enable  [N];
    logic [127:0] read_bus     [N];
    logic [19:0]  data_out     [N];
    logic         out_valid    [N];
    logic         out_ready    [N];
    logic [31:0]  out_count    [N];
    logic         bus_ovr_en   [N];
    logic [127:0] bus_ovr      [N];

    int    n_checks    = 0;
    int    n_fails     = 0;
    int    cyc         = 0;
    int    first_issue = -1;
    int    first_valid = -1;
    item_t pend_q [$];
    logic [19:0] exp_q [$];

    always #5 clock = ~clock;

    // -------------------------------------------------------------------------
    // Memory model and expected-value helpers
    // -------------------------------------------------------------------------
    function automatic logic [127:0] mem_word(input logic [15:0] a);
        logic [127:0] w;
        logic [1:0]   ln;
        w = '0;
        for (int l = 0; l < 4; l++) begin
            ln = 2'(l);
            w[l*32 +: 32] = {12'hA5A, 4'h5, a[15], 3'b000, a[5:0], ln, 4'hC};
        end
        return w;
    endfunction

    function automatic item_t mk(input logic [7:0] pix, input logic bank, input logic byp);
        item_t it;
        it.pix  = pix;
        it.bank = bank;
        it.byp  = byp;
        it.exp  = byp ? {12'h000, pix} : {4'h5, bank, 3'b000, pix[7:2], pix[1:0], 4'hC};
        return it;
    endfunction

    // -------------------------------------------------------------------------
    // DUTs and their memories
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 0 : ((k == 1) ? 2 : 3);

        logic [15:0] addr_line [5];
        logic        vld_line  [5];
        logic [15:0] ret_addr;
        logic        ret_vld;

        output_fetch_cdf_pipe #(
            .READ_LATENCY (LAT)
        ) u_dut (
            .clock              (clock),
            .reset              (reset),
            .DataIn             (data_in[k]),
            .InValid            (in_valid[k]),
            .InReady            (in_ready[k]),
            .Bypass             (bypass[k]),
            .output_base_offset (base[k]),
            .ReadAddress        (read_address[k]),
            .ReadEnable         (read_enable[k]),
            .ReadBus            (read_bus[k]),
            .DataOut            (data_out[k]),
            .OutValid           (out_valid[k]),
            .OutReady           (out_ready[k]),
            .OutCount           (out_count[k])
        );

        // The memory is never reset: reads in flight across a DUT reset still
        // come back on the bus, and the DUT must ignore them.
        always @(posedge clock) begin
            addr_line[0] <= read_address[k];
            vld_line[0]  <= read_enable[k];
            for (int i = 1; i < 5; i++) begin
                addr_line[i] <= addr_line[i-1];
                vld_line[i]  <= vld_line[i-1];
            end
        end

        if (LAT == 0) begin : g_l0
            assign ret_addr = read_address[k];
            assign ret_vld  = read_enable[k];
        end else begin : g_ln
            assign ret_addr = addr_line[LAT-1];
            assign ret_vld  = vld_line[LAT-1];
        end

        assign read_bus[k] = bus_ovr_en[k] ? bus_ovr[k]
                                           : (ret_vld ? mem_word(ret_addr) : GARBAGE);
    end

    // -------------------------------------------------------------------------
    // Bench utilities
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            bypass[k]    = 1'b0;
        end
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    // Drives pending pixels into instance k, checks every popped result against
    // the expected queue, and stops when both queues are empty or the budget
    // runs out. With must_finish set, a budget overrun counts as a failure.
    task automatic run(input int k, input int max_cycles, input bit must_finish);
        int n;
        n = 0;
        while (n < max_cycles && (pend_q.size() != 0 || exp_q.size() != 0)) begin
            if (pend_q.size() != 0) begin
                in_valid[k] = 1'b1;
                data_in[k]  = pend_q[0].pix;
                base[k]     = pend_q[0].bank;
                bypass[k]   = pend_q[0].byp;
            end else begin
                in_valid[k] = 1'b0;
            end
            #1;
            if (out_valid[k] && first_valid < 0) first_valid = cyc;
            if (out_valid[k] && out_ready[k]) begin
                if (exp_q.size() == 0) check("spurious_out", 32'(out_valid[k]), 32'd0);
                else                   check("data_out", 32'(data_out[k]), 32'(exp_q.pop_front()));
            end
            if (in_valid[k] && in_ready[k]) begin
                check("read_enable", 32'(read_enable[k]), 32'(!pend_q[0].byp));
                if (!pend_q[0].byp)
                    check("read_address", 32'(read_address[k]),
                          32'({pend_q[0].bank, 9'b0, pend_q[0].pix[7:2]}));
                if (first_issue < 0) first_issue = cyc;
                exp_q.push_back(pend_q[0].exp);
                void'(pend_q.pop_front());
            end
            step();
            cyc++;
            n++;
        end
        in_valid[k] = 1'b0;
        if (must_finish) check("run_done", 32'(pend_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Directed tests
    // -------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            data_in[k]    = 8'h07;
            in_valid[k]   = 1'b1;
            bypass[k]     = 1'b0;
            base[k]       = 1'b1;
            out_ready[k]  = 1'b1;
            bus_ovr_en[k] = 1'b0;
            bus_ovr[k]    = '0;
        end

        // Reset state: input held valid, yet nothing may be accepted or read.
        step();
        step();
        for (int k = 0; k < N; k++) begin
            check("rst_in_ready",    32'(in_ready[k]),    32'd0);
            check("rst_read_enable", 32'(read_enable[k]), 32'd0);
            check("rst_out_valid",   32'(out_valid[k]),   32'd0);
            check("rst_data_out",    32'(data_out[k]),    32'd0);
            check("rst_out_count",   out_count[k],        32'd0);
        end
        for (int k = 0; k < N; k++) in_valid[k] = 1'b0;
        reset = 1'b0;
        #1;

        // Latency 0: pixel 0x07 in bank 1 reads lane 3 of word 0x8001.
        bus_ovr[0]    = {32'h000ABCDE, 32'h00011111, 32'h00022222, 32'h00033333};
        bus_ovr_en[0] = 1'b1;
        out_ready[0]  = 1'b1;
        first_issue   = -1;
        first_valid   = -1;
        pend_q.push_back('{pix: 8'h07, bank: 1'b1, byp: 1'b0, exp: 20'hABCDE});
        run(0, 10, 1'b1);
        check("t1_latency",   32'(first_valid - first_issue), 32'd1);
        check("t1_out_count", out_count[0], 32'd1);
        bus_ovr_en[0] = 1'b0;

        // Latency 3: back-to-back pixels 0..3 pick lanes 0..3 in order.
        do_reset();
        out_ready[2] = 1'b1;
        first_issue  = -1;
        first_valid  = -1;
        for (int p = 0; p < 4; p++) pend_q.push_back(mk(8'(p), 1'b0, 1'b0));
        run(2, 30, 1'b1);
        check("t2_latency",   32'(first_valid - first_issue), 32'd4);
        check("t2_out_count", out_count[2], 32'd4);

        // Backpressure: only FIFO_DEPTH pixels are accepted while OutReady is low.
        do_reset();
        out_ready[0] = 1'b0;
        for (int p = 0; p < 6; p++) pend_q.push_back(mk(8'h10 + 8'(p), 1'(p), 1'b0));
        run(0, 8, 1'b0);
        check("t3_accepted",     32'(6 - pend_q.size()), 32'd4);
        check("t3_in_ready_low", 32'(in_ready[0]),  32'd0);
        check("t3_out_valid",    32'(out_valid[0]), 32'd1);
        out_ready[0] = 1'b1;
        run(0, 40, 1'b1);
        check("t3_out_count", out_count[0], 32'd6);

        // Bypass between two mapped pixels at latency 2.
        do_reset();
        out_ready[1] = 1'b1;
        pend_q.push_back(mk(8'h3C, 1'b0, 1'b0));
        pend_q.push_back(mk(8'hA5, 1'b0, 1'b1));
        pend_q.push_back(mk(8'hC3, 1'b1, 1'b0));
        run(1, 30, 1'b1);
        check("t4_out_count", out_count[1], 32'd3);

        // Simultaneous pop and issue with three entries held.
        do_reset();
        out_ready[0] = 1'b0;
        for (int p = 0; p < 3; p++) pend_q.push_back(mk(8'h21 + 8'(p), 1'b1, 1'b0));
        run(0, 6, 1'b0);
        check("t5_one_credit", 32'(in_ready[0]), 32'd1);
        pend_q.push_back(mk(8'h24, 1'b0, 1'b0));
        out_ready[0] = 1'b1;
        run(0, 1, 1'b0);
        out_ready[0] = 1'b0;
        check("t5_pop_count",     out_count[0],        32'd1);
        check("t5_credit_kept",   32'(in_ready[0]),    32'd1);
        check("t5_still_valid",   32'(out_valid[0]),   32'd1);
        pend_q.push_back(mk(8'h25, 1'b1, 1'b0));
        run(0, 3, 1'b0);
        check("t5_full_no_ready", 32'(in_ready[0]),    32'd0);
        out_ready[0] = 1'b1;
        run(0, 30, 1'b1);
        check("t5_out_count",     out_count[0],        32'd5);

        // Reset with two results in the FIFO and two reads in flight.
        do_reset();
        out_ready[2] = 1'b1;
        pend_q.push_back(mk(8'h40, 1'b0, 1'b0));
        pend_q.push_back(mk(8'h41, 1'b1, 1'b0));
        run(2, 20, 1'b1);
        out_ready[2] = 1'b0;
        for (int p = 0; p < 4; p++) pend_q.push_back(mk(8'h50 + 8'(p), 1'b1, 1'b0));
        run(2, 5, 1'b0);
        reset       = 1'b1;
        in_valid[2] = 1'b1;
        data_in[2]  = 8'h66;
        bypass[2]   = 1'b0;
        step();
        check("t6_out_valid",   32'(out_valid[2]),   32'd0);
        check("t6_data_out",    32'(data_out[2]),    32'd0);
        check("t6_out_count",   out_count[2],        32'd0);
        check("t6_in_ready",    32'(in_ready[2]),    32'd0);
        check("t6_read_enable", 32'(read_enable[2]), 32'd0);
        in_valid[2] = 1'b0;
        reset       = 1'b0;
        #1;
        check("t6_in_ready_back", 32'(in_ready[2]), 32'd1);
        exp_q.delete();
        pend_q.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_no_stale", 32'(out_valid[2]), 32'd0);
        end
        out_ready[2] = 1'b1;
        pend_q.push_back(mk(8'h77, 1'b1, 1'b0));
        run(2, 20, 1'b1);
        check("t6_out_count_after", out_count[2], 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
